// File: rtl/vedic_mac_12.sv
`default_nettype none
// ============================================================================
// Module      : mult_12x12
// Description : 12x12 unsigned multiplier, Urdhva-Tiryagbhyam (vertical and
//               crosswise) style. Operands are split into three 4-bit digits.
//               Every digit-pair product is weighted by its column (i+j) and
//               summed. The result is the full 24-bit product.
// Ports       : a [11:0] in  - multiplicand
//               b [11:0] in  - multiplier
//               p [23:0] out - a*b
// Revision    : 1.0 - initial release
// ============================================================================
module mult_12x12 (
   input  logic [11:0] a,
   input  logic [11:0] b,
   output logic [23:0] p
);

   logic [7:0]  w_pp;
   logic [23:0] w_sum;

   always_comb begin
      w_sum = 24'd0;
      w_pp  = 8'd0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w_pp  = 8'(a[4*i +: 4]) * 8'(b[4*j +: 4]);
            // Column weight is 16^(i+j). The total never exceeds 24 bits.
            w_sum = w_sum + (24'(w_pp) << (4 * (i + j)));
         end
      end
      p = w_sum;
   end

endmodule

// ============================================================================
// Module      : vedic_mac_12
// Description : Multiply-accumulate engine. A run starts with start/len while
//               the block is idle. It then takes len a/b pairs (len 0 means
//               256) through a valid/ready handshake. Each product is first
//               registered, then added to the accumulator one cycle later.
//               The run's sum and a sticky carry-out flag are held until
//               downstream accepts them.
// Ports       : clk, rst_n     - clock / synchronous active-low reset
//               start, len     - launch a run of len pairs (sampled in IDLE)
//               in_valid/ready - operand handshake, a/b 12-bit unsigned
//               out_valid/ready- result handshake
//               acc_out, ovf   - accumulated sum (mod 2^ACC_W), carry flag
//               busy           - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_mac_12 #(
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [11:0]      a,
   input  logic [11:0]      b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [8:0]       cnt_q, cnt_d;        // 9 bits so a len of 0 can hold 256
   logic [23:0]      prod_q, prod_d;      // stage-1 product register
   logic             prod_vld_q, prod_vld_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic [23:0]      w_prod;
   logic             w_accept;
   logic [ACC_W:0]   w_add;               // extra MSB captures the carry-out

   mult_12x12 u_mult_12x12 (
      .a (a),
      .b (b),
      .p (w_prod)
   );

   assign w_accept = (state_q == ST_RUN) && in_valid;
   assign w_add    = {1'b0, acc_q} + {{(ACC_W + 1 - 24){1'b0}}, prod_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      prod_vld_d = w_accept;
      acc_d      = acc_q;
      ovf_d      = ovf_q;

      if (w_accept) begin
         prod_d = w_prod;
      end

      // Stage 2: fold the registered product into the accumulator.
      if (prod_vld_q) begin
         acc_d = w_add[ACC_W-1:0];
         ovf_d = ovf_q | w_add[ACC_W];
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               cnt_d      = (len == 8'd0) ? 9'd256 : {1'b0, len};
               acc_d      = '0;
               ovf_d      = 1'b0;
               prod_vld_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (w_accept) begin
               cnt_d = cnt_q - 9'd1;
               if (cnt_q == 9'd1) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // The last product is added on the first DRAIN cycle. Leave once
            // the pipeline is empty, so out_valid appears two edges after the
            // final acceptance.
            if (!prod_vld_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 9'd0;
         prod_q     <= 24'd0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_RUN);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_vedic_mac_12.sv
`default_nettype none
// ============================================================================
// Module      : tb_vedic_mac_12
// Description : Scoreboard bench for vedic_mac_12. It drives a 32-bit and a
//               24-bit accumulator instance from the same stimulus. For each
//               run the driver computes the expected sum and carry flag with
//               plain 64-bit arithmetic and queues them. A monitor pops the
//               queue and compares on every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vedic_mac_12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = 8'd0;
   logic        in_valid = 1'b0;
   logic [11:0] a = 12'd0;
   logic [11:0] b = 12'd0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, busy, ovf;
   logic [31:0] acc_out;
   logic        in_ready24, out_valid24, busy24, ovf24;
   logic [23:0] acc_out24;

   int n_checks = 0;
   int n_errors = 0;
   int accept_cnt = 0;

   logic [32:0] exp32_q[$];   // {ovf, acc}
   logic [32:0] exp24_q[$];

   logic [11:0] a_arr[256];
   logic [11:0] b_arr[256];

   always #5 clk = ~clk;

   vedic_mac_12 u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .acc_out(acc_out), .ovf(ovf), .busy(busy)
   );

   vedic_mac_12 #(.ACC_W(24)) u_dut24 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready24), .a(a), .b(b),
      .out_valid(out_valid24), .out_ready(out_ready),
      .acc_out(acc_out24), .ovf(ovf24), .busy(busy24)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) accept_cnt++;
      if (rst_n && out_valid && out_ready) begin
         if (exp32_q.size() == 0) begin
            chk("unexpected_result32", 64'(acc_out), 64'hDEAD);
         end else begin
            logic [32:0] e;
            e = exp32_q.pop_front();
            chk("acc32", 64'(acc_out), 64'(e[31:0]));
            chk("ovf32", 64'(ovf), 64'(e[32]));
         end
         if (exp24_q.size() == 0) begin
            chk("unexpected_result24", 64'(acc_out24), 64'hDEAD);
         end else begin
            logic [32:0] e;
            e = exp24_q.pop_front();
            chk("ovf24_valid", 64'(out_valid24), 64'd1);
            chk("acc24", 64'(acc_out24), 64'(e[23:0]));
            chk("ovf24", 64'(ovf24), 64'(e[32]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 2000) begin
         tick();
         t++;
      end
      if (busy) chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_busy"},      64'(busy),      64'd0);
      chk({tag, "_acc32"},     64'(acc_out),   64'd0);
      chk({tag, "_ovf32"},     64'(ovf),       64'd0);
      chk({tag, "_acc24"},     64'(acc_out24), 64'd0);
      chk({tag, "_ovf24"},     64'(ovf24),     64'd0);
   endtask

   // Reference: plain sum of products, reduced modulo the accumulator width.
   task automatic push_expected(input int n);
      logic [63:0] sum;
      sum = 64'd0;
      for (int i = 0; i < n; i++) sum = sum + 64'(a_arr[i]) * 64'(b_arr[i]);
      exp32_q.push_back({sum >= (64'd1 << 32), sum[31:0]});
      exp24_q.push_back({sum >= (64'd1 << 24), 8'd0, sum[23:0]});
   endtask

   task automatic drive_pair(input int i, input bit gaps);
      int t;
      if (gaps && i > 0) begin
         in_valid = 1'b0;
         a = 12'($urandom);
         b = 12'($urandom);
         repeat ($urandom_range(1, 2)) tick();
      end
      a = a_arr[i];
      b = b_arr[i];
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 20) begin
         tick();
         t++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      tick();
   endtask

   task automatic do_run(input int n, input bit gaps, input int hold, input bit start_in_done);
      int seen;
      logic [31:0] held;
      wait_idle();
      push_expected(n);
      seen = accept_cnt;
      start = 1'b1;
      len = n[7:0];
      tick();
      start = 1'b0;
      len = 8'($urandom);
      for (int i = 0; i < n; i++) drive_pair(i, gaps);
      // Bubbles carrying garbage operands must not be accumulated.
      in_valid = 1'b0;
      a = 12'($urandom);
      b = 12'($urandom);
      chk("accept_count", 64'(accept_cnt - seen), 64'(n));
      chk("out_valid_lat0", 64'(out_valid), 64'd0);
      tick();
      chk("out_valid_lat1", 64'(out_valid), 64'd0);
      tick();
      chk("out_valid_lat2", 64'(out_valid), 64'd1);
      held = acc_out;
      for (int k = 0; k < hold; k++) begin
         start = start_in_done && (k == 1);
         tick();
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_acc", 64'(acc_out), 64'(held));
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_done_busy", 64'(busy), 64'd0);
      chk("post_done_valid", 64'(out_valid), 64'd0);
      chk("post_done_acc_kept", 64'(acc_out), 64'(held));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      chk_all_zero("reset");

      // Single maximal product.
      a_arr[0] = 12'hFFF; b_arr[0] = 12'hFFF;
      do_run(1, 1'b0, 5, 1'b1);

      // len=0 means 256 pairs, back to back.
      for (int i = 0; i < 256; i++) begin
         a_arr[i] = 12'hFFF;
         b_arr[i] = 12'hFFF;
      end
      do_run(256, 1'b0, 0, 1'b0);

      // Two maximal products overflow the 24-bit accumulator.
      do_run(2, 1'b0, 1, 1'b0);

      // Small pairs with bubbles between them.
      a_arr[0] = 12'd2; b_arr[0] = 12'd3;
      a_arr[1] = 12'd4; b_arr[1] = 12'd5;
      a_arr[2] = 12'd6; b_arr[2] = 12'd7;
      do_run(3, 1'b1, 2, 1'b0);

      // Reset in the middle of a run discards everything accepted so far.
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         a_arr[i] = 12'hABC;
         b_arr[i] = 12'h123;
      end
      start = 1'b1;
      len = 8'd4;
      tick();
      start = 1'b0;
      drive_pair(0, 1'b0);
      drive_pair(1, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_all_zero("midrun_reset");
      a_arr[0] = 12'd2; b_arr[0] = 12'd3;
      do_run(1, 1'b0, 0, 1'b0);

      // Randomised runs.
      for (int r = 0; r < 10; r++) begin
         int n;
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) begin
            a_arr[i] = 12'($urandom_range(0, 4095));
            b_arr[i] = 12'($urandom_range(0, 4095));
         end
         do_run(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      tick();
      chk("scoreboard32_empty", 64'(exp32_q.size()), 64'd0);
      chk("scoreboard24_empty", 64'(exp24_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
